// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the frequency-sweep controller: data widths, the
// timeout marker stored in place of a measurement, the FSM state encoding
// and the point-count clamp.
package sweep_ctrl_pkg;

  localparam int unsigned KW_W  = 32;
  localparam int unsigned VPP_W = 12;

  localparam logic [VPP_W-1:0] TIMEOUT_CODE = 12'hFFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_SETTLE   = 3'd2;
  localparam state_t ST_ARM      = 3'd3;
  localparam state_t ST_WAIT_VPP = 3'd4;
  localparam state_t ST_STORE    = 3'd5;
  localparam state_t ST_NEXT     = 3'd6;
  localparam state_t ST_DONE     = 3'd7;

  // Requested points clamped to 1..max_pts.
  function automatic logic [7:0] eff_count(input logic [7:0] n,
                                           input logic [7:0] max_pts);
    if (n == 8'd0)        return 8'd1;
    else if (n > max_pts) return max_pts;
    else                  return n;
  endfunction

endpackage

// File: rtl/sweep_ctrl_if.sv
// Host-side bundle of sweep_ctrl: sweep command/configuration, status and
// the result-buffer read port.
//   slave  : the controller (consumes commands, drives status and rd_data)
//   master : the host (drives commands and rd_addr)
interface sweep_ctrl_if;
  import sweep_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic [KW_W-1:0]  kw_start;
  logic [KW_W-1:0]  kw_step;
  logic [KW_W-1:0]  samp_delta;
  logic [7:0]       n_points;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [7:0]       pts_done;
  logic [7:0]       rd_addr;
  logic [VPP_W-1:0] rd_data;

  modport slave (
    input  start, abort, kw_start, kw_step, samp_delta, n_points, rd_addr,
    output busy, done, timeout_err, pts_done, rd_data
  );

  modport master (
    output start, abort, kw_start, kw_step, samp_delta, n_points, rd_addr,
    input  busy, done, timeout_err, pts_done, rd_data
  );

endinterface

// File: rtl/sweep_buf.sv
// Sweep result buffer: N_PTS x VPP_W simple dual-port RAM.
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : registered read port, one-cycle latency; addresses
//                    outside the buffer read as zero; a same-cycle read and
//                    write of one address returns the old word.
module sweep_buf
  import sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_PTS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [VPP_W-1:0] wdata,
  input  logic [7:0]       raddr,
  output logic [VPP_W-1:0] rdata
);

  localparam int unsigned AW    = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam logic [8:0]  DEPTH = 9'(N_PTS);

  logic [VPP_W-1:0] mem [N_PTS];
  logic [VPP_W-1:0] rdata_d, rdata_q;
  logic             waddr_ok, raddr_ok;

  assign waddr_ok = {1'b0, waddr} < DEPTH;
  assign raddr_ok = {1'b0, raddr} < DEPTH;

  always_ff @(posedge clk) begin
    if (we && waddr_ok) mem[waddr[AW-1:0]] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    if (raddr_ok) rdata_d = mem[raddr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller. Steps a DDS control word from kw_start by
// kw_step, waits for the analogue path to settle, then collects one Vpp
// result per point from the measurement block (or the timeout marker) into
// a result buffer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   host (slave)    : start/abort, sweep configuration, status, buffer read
//   vpp_in          : measurement result, valid on a vpp_found rising edge
//   vpp_found       : from the sample-clock domain, synchronized here
//   kw_out, kw2_out : main and sampling-clock DDS control words
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_PTS       = 64,
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  sweep_ctrl_if.slave      host,
  input  logic [VPP_W-1:0] vpp_in,
  input  logic             vpp_found,
  output logic [KW_W-1:0]  kw_out,
  output logic [KW_W-1:0]  kw2_out
);

  localparam logic [7:0]  MAX_PTS      = 8'(N_PTS);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t           state_d, state_q;
  logic [KW_W-1:0]  kw_d, kw_q, kw2_d, kw2_q;
  logic [KW_W-1:0]  kws_d, kws_q, step_d, step_q, sd_d, sd_q;
  logic [7:0]       eff_d, eff_q, idx_d, idx_q, pts_d, pts_q;
  logic [31:0]      cnt_d, cnt_q;
  logic [VPP_W-1:0] cap_d, cap_q;
  logic             terr_d, terr_q;
  logic [2:0]       sync_d, sync_q;
  logic             found_rise, wr_en;

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous value.
  assign sync_d     = {sync_q[1:0], vpp_found};
  assign found_rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d = state_q;
    kw_d    = kw_q;
    kw2_d   = kw_q + sd_q;
    kws_d   = kws_q;
    step_d  = step_q;
    sd_d    = sd_q;
    eff_d   = eff_q;
    idx_d   = idx_q;
    pts_d   = pts_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    terr_d  = terr_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host.start && !host.abort) begin
          kws_d   = host.kw_start;
          step_d  = host.kw_step;
          sd_d    = host.samp_delta;
          eff_d   = eff_count(host.n_points, MAX_PTS);
          pts_d   = '0;
          terr_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        kw_d    = kws_q;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_ARM;
        else                      cnt_d   = cnt_q + 32'd1;
      end
      ST_ARM: begin
        // An edge seen here belongs to a measurement started before the
        // frequency step, so it is dropped.
        cnt_d   = '0;
        state_d = ST_WAIT_VPP;
      end
      ST_WAIT_VPP: begin
        if (found_rise) begin
          cap_d   = vpp_in;
          state_d = ST_STORE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cap_d   = TIMEOUT_CODE;
          terr_d  = 1'b1;
          state_d = ST_STORE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STORE: begin
        wr_en   = 1'b1;
        pts_d   = idx_q + 8'd1;
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == eff_q - 8'd1) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          kw_d    = kw_q + step_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort freezes the visible results exactly as they stood.
    if (host.abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
      kw_d    = kw_q;
      pts_d   = pts_q;
      terr_d  = terr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kw_q    <= '0;
      kw2_q   <= '0;
      kws_q   <= '0;
      step_q  <= '0;
      sd_q    <= '0;
      eff_q   <= 8'd1;
      idx_q   <= '0;
      pts_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      terr_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      kw_q    <= kw_d;
      kw2_q   <= kw2_d;
      kws_q   <= kws_d;
      step_q  <= step_d;
      sd_q    <= sd_d;
      eff_q   <= eff_d;
      idx_q   <= idx_d;
      pts_q   <= pts_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      terr_q  <= terr_d;
      sync_q  <= sync_d;
    end
  end

  sweep_buf #(.N_PTS(N_PTS)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (idx_q),
    .wdata (cap_q),
    .raddr (host.rd_addr),
    .rdata (host.rd_data)
  );

  assign host.busy        = (state_q != ST_IDLE);
  assign host.done        = (state_q == ST_DONE);
  assign host.timeout_err = terr_q;
  assign host.pts_done    = pts_q;
  assign kw_out           = kw_q;
  assign kw2_out          = kw2_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] vpp_in = '0;
  logic        vpp_found = 1'b0;
  logic [31:0] kw_out, kw2_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;

  sweep_ctrl_if host ();

  sweep_ctrl #(.N_PTS(64), .SETTLE_CYC(4), .TIMEOUT_CYC(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host),
    .vpp_in    (vpp_in),
    .vpp_found (vpp_found),
    .kw_out    (kw_out),
    .kw2_out   (kw2_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (host.done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] ks, input logic [31:0] st,
                             input logic [31:0] sd, input logic [7:0] n);
    host.kw_start = ks; host.kw_step = st; host.samp_delta = sd; host.n_points = n;
    host.start = 1'b1;
    tick();
    host.start = 1'b0;
  endtask

  task automatic wait_kw(input logic [31:0] kw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (kw_out === kw) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      if (host.busy === 1'b0) ok = 1'b1;
      else tick();
    end
  endtask

  // Waits for kw, returns kw2 one cycle later, then raises vpp_found
  // 10 cycles after ARM (ARM follows the kw_out update by 4 cycles).
  task automatic do_point(input logic [31:0] kw, input logic [11:0] vpp,
                          output bit ok, output logic [31:0] kw2_seen);
    wait_kw(kw, ok);
    tick();
    kw2_seen = kw2_out;
    repeat (13) tick();
    vpp_in = vpp;
    vpp_found = 1'b1;
    repeat (4) tick();
    vpp_found = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", host.busy); end
    n_cmp++; if (host.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", host.done); end
    n_cmp++; if (host.timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr got %0b want 0", host.timeout_err); end
    n_cmp++; if (host.pts_done !== 8'd0) begin n_bad++; $display("FAIL reset_pts got %0d want 0", host.pts_done); end
    n_cmp++; if (kw_out !== 32'd0) begin n_bad++; $display("FAIL reset_kw got %0h want 0", kw_out); end
    n_cmp++; if (kw2_out !== 32'd0) begin n_bad++; $display("FAIL reset_kw2 got %0h want 0", kw2_out); end
    n_cmp++; if (host.rd_data !== 12'd0) begin n_bad++; $display("FAIL reset_rd got %0h want 0", host.rd_data); end
  endtask

  task automatic test_basic_sweep();
    bit ok;
    logic [31:0] kw2;
    logic [31:0] kw_exp [3] = '{32'd1000, 32'd1500, 32'd2000};
    logic [11:0] vpp_v [3] = '{12'd100, 12'd200, 12'd300};
    int d0 = done_cnt;
    pulse_start(32'd1000, 32'd500, 32'h10, 8'd3);
    for (int k = 0; k < 3; k++) begin
      do_point(kw_exp[k], vpp_v[k], ok, kw2);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_kw%0d got %0d want %0d", k, kw_out, kw_exp[k]); end
      n_cmp++; if (kw2 !== kw_exp[k] + 32'h10) begin n_bad++; $display("FAIL basic_kw2_%0d got %0d want %0d", k, kw2, kw_exp[k] + 32'h10); end
    end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_idle got busy=%0b want 0", host.busy); end
    n_cmp++; if (host.pts_done !== 8'd3) begin n_bad++; $display("FAIL basic_pts got %0d want 3", host.pts_done); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (host.timeout_err !== 1'b0) begin n_bad++; $display("FAIL basic_terr got %0b want 0", host.timeout_err); end
    for (int k = 0; k < 3; k++) begin
      host.rd_addr = 8'(k);
      tick();
      n_cmp++; if (host.rd_data !== vpp_v[k]) begin n_bad++; $display("FAIL basic_buf%0d got %0d want %0d", k, host.rd_data, vpp_v[k]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] kw2;
    pulse_start(32'hFFFF_FF00, 32'h200, 32'h300, 8'd2);
    do_point(32'hFFFF_FF00, 12'd5, ok, kw2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_kw0 got %0h want ffffff00", kw_out); end
    n_cmp++; if (kw2 !== 32'h200) begin n_bad++; $display("FAIL wrap_kw2_0 got %0h want 200", kw2); end
    do_point(32'h100, 12'd6, ok, kw2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_kw1 got %0h want 100", kw_out); end
    n_cmp++; if (kw2 !== 32'h400) begin n_bad++; $display("FAIL wrap_kw2_1 got %0h want 400", kw2); end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_idle got busy=%0b want 0", host.busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int d0 = done_cnt;
    pulse_start(32'd0, 32'd1, 32'd0, 8'd2);
    wait_idle(300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_idle got busy=%0b want 0", host.busy); end
    n_cmp++; if (host.timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_terr got %0b want 1", host.timeout_err); end
    n_cmp++; if (host.pts_done !== 8'd2) begin n_bad++; $display("FAIL to_pts got %0d want 2", host.pts_done); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL to_done got %0d pulses want 1", done_cnt - d0); end
    for (int k = 0; k < 2; k++) begin
      host.rd_addr = 8'(k);
      tick();
      n_cmp++; if (host.rd_data !== 12'hFFF) begin n_bad++; $display("FAIL to_buf%0d got %0h want fff", k, host.rd_data); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    logic [31:0] kw2;
    int d0 = done_cnt;
    pulse_start(32'd10, 32'd1, 32'd0, 8'd4);
    n_cmp++; if (host.timeout_err !== 1'b0) begin n_bad++; $display("FAIL ab_terr_clr got %0b want 0", host.timeout_err); end
    n_cmp++; if (host.pts_done !== 8'd0) begin n_bad++; $display("FAIL ab_pts_clr got %0d want 0", host.pts_done); end
    do_point(32'd10, 12'd77, ok, kw2);
    wait_kw(32'd11, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ab_kw1 got %0d want 11", kw_out); end
    repeat (7) tick();
    host.abort = 1'b1;
    tick();
    host.abort = 1'b0;
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy got %0b want 0", host.busy); end
    n_cmp++; if (host.pts_done !== 8'd1) begin n_bad++; $display("FAIL ab_pts got %0d want 1", host.pts_done); end
    n_cmp++; if (kw_out !== 32'd11) begin n_bad++; $display("FAIL ab_kw_hold got %0d want 11", kw_out); end
    repeat (5) tick();
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL ab_nodone got %0d pulses want 0", done_cnt - d0); end
    host.rd_addr = 8'd0;
    tick();
    n_cmp++; if (host.rd_data !== 12'd77) begin n_bad++; $display("FAIL ab_buf0 got %0d want 77", host.rd_data); end
    host.start = 1'b1; host.abort = 1'b1;
    tick();
    host.start = 1'b0; host.abort = 1'b0;
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL ab_start_busy got %0b want 0", host.busy); end
    n_cmp++; if (host.pts_done !== 8'd1) begin n_bad++; $display("FAIL ab_start_pts got %0d want 1", host.pts_done); end
  endtask

  task automatic test_count_limits();
    bit ok;
    int d0;
    pulse_start(32'd42, 32'd1, 32'd0, 8'd0);
    n_cmp++; if (host.pts_done !== 8'd0) begin n_bad++; $display("FAIL lim_pts_clr got %0d want 0", host.pts_done); end
    wait_idle(300, ok);
    n_cmp++; if (!ok || host.pts_done !== 8'd1) begin n_bad++; $display("FAIL lim_n0 got pts=%0d busy=%0b want 1 0", host.pts_done, host.busy); end
    n_cmp++; if (kw_out !== 32'd42) begin n_bad++; $display("FAIL lim_n0_kw got %0d want 42", kw_out); end
    d0 = done_cnt;
    pulse_start(32'd0, 32'd3, 32'd7, 8'd200);
    repeat (10) tick();
    pulse_start(32'd5000, 32'd1, 32'd0, 8'd1);
    wait_idle(5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL lim_idle got busy=%0b want 0", host.busy); end
    n_cmp++; if (host.pts_done !== 8'd64) begin n_bad++; $display("FAIL lim_pts got %0d want 64", host.pts_done); end
    n_cmp++; if (kw_out !== 32'd189) begin n_bad++; $display("FAIL lim_kw got %0d want 189", kw_out); end
    n_cmp++; if (kw2_out !== 32'd196) begin n_bad++; $display("FAIL lim_kw2 got %0d want 196", kw2_out); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL lim_done got %0d pulses want 1", done_cnt - d0); end
    host.rd_addr = 8'd64;
    tick();
    n_cmp++; if (host.rd_data !== 12'd0) begin n_bad++; $display("FAIL lim_rd64 got %0h want 0", host.rd_data); end
    host.rd_addr = 8'd63;
    tick();
    n_cmp++; if (host.rd_data !== 12'hFFF) begin n_bad++; $display("FAIL lim_rd63 got %0h want fff", host.rd_data); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start(32'd777, 32'd1, 32'd9, 8'd3);
    wait_kw(32'd777, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rm_kw got %0d want 777", kw_out); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (host.busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %0b want 0", host.busy); end
    n_cmp++; if (kw_out !== 32'd0) begin n_bad++; $display("FAIL rm_kw0 got %0d want 0", kw_out); end
    n_cmp++; if (kw2_out !== 32'd0) begin n_bad++; $display("FAIL rm_kw2 got %0d want 0", kw2_out); end
    n_cmp++; if (host.pts_done !== 8'd0) begin n_bad++; $display("FAIL rm_pts got %0d want 0", host.pts_done); end
    n_cmp++; if (host.rd_data !== 12'd0) begin n_bad++; $display("FAIL rm_rd got %0h want 0", host.rd_data); end
    n_cmp++; if (host.done !== 1'b0 || host.timeout_err !== 1'b0) begin n_bad++; $display("FAIL rm_flags got done=%0b terr=%0b want 0 0", host.done, host.timeout_err); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    n_cmp++; if (host.busy !== 1'b0 || kw_out !== 32'd0) begin n_bad++; $display("FAIL rm_noresume got busy=%0b kw=%0d want 0 0", host.busy, kw_out); end
  endtask

  initial begin
    host.start = 1'b0; host.abort = 1'b0; host.rd_addr = '0;
    host.kw_start = '0; host.kw_step = '0; host.samp_delta = '0; host.n_points = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic_sweep();
    test_wrap();
    test_timeout();
    test_abort();
    test_count_limits();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
